// File: rtl/waveform_defs.sv
// Shared definitions for the waveform generator / period meter pair:
// default counter width, meter FSM encodings and the SILENT code.
package waveform_defs;

  localparam int DefaultNumberOfBits = 20;

  // HalfPeriod code meaning "no tone"; the generator treats it the same way
  localparam int SILENT = 0;

  typedef enum logic {
    ACQUIRE = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

endpackage

// File: rtl/waveform_edge_detect.sv
// Input register plus previous-level register; flags any level change.
// Define WAVEFORM_METER_SYNC_EN to add a 2-flop synchronizer in front.
module waveform_edge_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic Waveform,
  output logic Edge,
  output logic Level
);

  logic level_q;
  logic prev_q;

`ifdef WAVEFORM_METER_SYNC_EN
  logic meta_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      meta_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      meta_q  <= Waveform;
      level_q <= meta_q;
    end
  end
`else
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= Waveform;
    end
  end
`endif

  // prev resets low so an input already high at reset release looks like a rising edge
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_q;
    end
  end

  assign Edge  = level_q ^ prev_q;
  assign Level = level_q;

endmodule

// File: rtl/waveform_period_meter.sv
// Half-period meter: reports clocks-between-edges minus one, 0 on timeout.
// Build option WAVEFORM_METER_SYNC_EN (in waveform_edge_detect) adds one clock of latency.
//
// state   | meaning
// ACQUIRE | waiting for an arming edge, no measurement in progress
// MEASURE | counting clocks since the last edge
module waveform_period_meter
  import waveform_defs::*;
#(
  parameter int NumberOfBits = DefaultNumberOfBits,
  parameter int Tolerance    = 0
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Waveform,
  output logic [NumberOfBits-1:0] HalfPeriod,
  output logic                    HalfPeriodValid,
  output logic                    Timeout,
  output logic                    Stable
);

  localparam int CW = NumberOfBits + 1;
  localparam logic [CW-1:0] CountLimit = {1'b1, {NumberOfBits{1'b0}}};
  localparam logic [CW-1:0] CountOne   = {{NumberOfBits{1'b0}}, 1'b1};
  localparam logic [NumberOfBits-1:0] TolVal = NumberOfBits'(Tolerance);

  logic wave_edge;
  logic wave_level;

  waveform_edge_detect u_edge (
    .Clock    (Clock),
    .Reset    (Reset),
    .Waveform (Waveform),
    .Edge     (wave_edge),
    .Level    (wave_level)
  );

  meter_state_t            state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NumberOfBits-1:0] prev_q, prev_d;
  logic                    have_prev_q, have_prev_d;
  logic [NumberOfBits-1:0] half_d;
  logic                    valid_d, timeout_d, stable_d;
  logic [NumberOfBits-1:0] meas, diff;

  // cnt holds D at the edge; D=1 reports 1 because 0 means silent
  assign meas = (cnt_q <= CountOne) ? NumberOfBits'(1) : NumberOfBits'(cnt_q - CountOne);
  assign diff = (meas >= prev_q) ? (meas - prev_q) : (prev_q - meas);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    half_d      = HalfPeriod;
    valid_d     = 1'b0;
    timeout_d   = Timeout;
    stable_d    = Stable;
    if (cnt_q != CountLimit) cnt_d = cnt_q + CountOne;
    case (state_q)
      ACQUIRE: begin
        if (wave_edge) begin
          cnt_d       = CountOne;
          have_prev_d = 1'b0;
          state_d     = MEASURE;
        end
      end
      MEASURE: begin
        // an edge landing on the timeout cycle is still a valid measurement
        if (wave_edge) begin
          half_d      = meas;
          valid_d     = 1'b1;
          timeout_d   = 1'b0;
          stable_d    = have_prev_q && (diff <= TolVal);
          prev_d      = meas;
          have_prev_d = 1'b1;
          cnt_d       = CountOne;
        end else if (cnt_q == CountLimit) begin
          half_d      = NumberOfBits'(SILENT);
          valid_d     = 1'b1;
          timeout_d   = 1'b1;
          stable_d    = 1'b0;
          have_prev_d = 1'b0;
          state_d     = ACQUIRE;
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q         <= ACQUIRE;
      cnt_q           <= '0;
      prev_q          <= '0;
      have_prev_q     <= 1'b0;
      HalfPeriod      <= '0;
      HalfPeriodValid <= 1'b0;
      Timeout         <= 1'b0;
      Stable          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      prev_q          <= prev_d;
      have_prev_q     <= have_prev_d;
      HalfPeriod      <= half_d;
      HalfPeriodValid <= valid_d;
      Timeout         <= timeout_d;
      Stable          <= stable_d;
    end
  end

endmodule

// File: tb/tb_waveform_period_meter.sv
// Random-stimulus bench for waveform_period_meter, two instances (Tolerance 0 and 1),
// checked against a timestamp-based model of edge spacing.
module tb_waveform_period_meter;

  localparam int N     = 5;
  localparam int LIMIT = 1 << N;
`ifdef WAVEFORM_METER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Waveform = 1'b0;

  logic [N-1:0] hp0, hp1;
  logic v0, t0, s0, v1, t1, s1;

  always #5 Clock = ~Clock;

  waveform_period_meter #(.NumberOfBits(N), .Tolerance(0)) u_tol0 (
    .Clock(Clock), .Reset(Reset), .Waveform(Waveform),
    .HalfPeriod(hp0), .HalfPeriodValid(v0), .Timeout(t0), .Stable(s0)
  );

  waveform_period_meter #(.NumberOfBits(N), .Tolerance(1)) u_tol1 (
    .Clock(Clock), .Reset(Reset), .Waveform(Waveform),
    .HalfPeriod(hp1), .HalfPeriodValid(v1), .Timeout(t1), .Stable(s1)
  );

  typedef struct {
    int cyc;
    int half;
    bit to;
    bit st0;
    bit st1;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  // model: edge timestamps in drive-cycle units
  logic mlvl = 1'b0;
  bit   armed = 1'b0;
  bit   have_prev = 1'b0;
  int   last_edge = 0;
  int   prev_meas = 0;
  int   e_half = 0;
  bit   e_to = 1'b0, e_st0 = 1'b0, e_st1 = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    bit ev;
    ev = (q.size() > 0) && (q[0].cyc == cyc);
    if (ev) begin
      e_half = q[0].half;
      e_to   = q[0].to;
      e_st0  = q[0].st0;
      e_st1  = q[0].st1;
      void'(q.pop_front());
    end
    check_eq("valid0",   32'(v0),  32'(ev));
    check_eq("valid1",   32'(v1),  32'(ev));
    check_eq("half0",    32'(hp0), e_half);
    check_eq("half1",    32'(hp1), e_half);
    check_eq("timeout0", 32'(t0),  32'(e_to));
    check_eq("timeout1", 32'(t1),  32'(e_to));
    check_eq("stable0",  32'(s0),  32'(e_st0));
    check_eq("stable1",  32'(s1),  32'(e_st1));
  endtask

  task automatic model_update();
    bit tog;
    int d, m, df;
    ev_t e;
    tog  = (Waveform !== mlvl);
    mlvl = Waveform;
    if (tog) begin
      if (!armed) begin
        armed     = 1'b1;
        have_prev = 1'b0;
        last_edge = cyc;
      end else begin
        d  = cyc - last_edge;
        m  = (d == 1) ? 1 : d - 1;
        df = (m > prev_meas) ? m - prev_meas : prev_meas - m;
        e.cyc = cyc + LAT; e.half = m; e.to = 1'b0;
        e.st0 = have_prev && (df <= 0);
        e.st1 = have_prev && (df <= 1);
        q.push_back(e);
        prev_meas = m;
        have_prev = 1'b1;
        last_edge = cyc;
      end
    end else if (armed && (cyc - last_edge == LIMIT)) begin
      e.cyc = cyc + LAT; e.half = 0; e.to = 1'b1; e.st0 = 1'b0; e.st1 = 1'b0;
      q.push_back(e);
      armed = 1'b0;
    end
  endtask

  task automatic step(input bit tog);
    @(posedge Clock);
    #1;
    cyc++;
    check_cycle();
    if (tog) Waveform = ~Waveform;
    model_update();
  endtask

  task automatic hold(input int d);
    repeat (d - 1) step(1'b0);
    step(1'b1);
  endtask

  task automatic do_reset(input logic lvl);
    #2 Reset = 1'b0;
    #1;
    check_eq("rst_half0",  32'(hp0), 0);
    check_eq("rst_half1",  32'(hp1), 0);
    check_eq("rst_valid0", 32'(v0),  0);
    check_eq("rst_valid1", 32'(v1),  0);
    check_eq("rst_to0",    32'(t0),  0);
    check_eq("rst_to1",    32'(t1),  0);
    check_eq("rst_st0",    32'(s0),  0);
    check_eq("rst_st1",    32'(s1),  0);
    Waveform = lvl;
    repeat (3) begin
      @(posedge Clock);
      cyc++;
    end
    #1;
    q.delete();
    armed = 1'b0; have_prev = 1'b0; mlvl = 1'b0;
    e_half = 0; e_to = 1'b0; e_st0 = 1'b0; e_st1 = 1'b0;
    Reset = 1'b1;
    model_update();
  endtask

  initial begin
    do_reset(1'b0);
    repeat (3) step(1'b0);
    step(1'b1);
    repeat (12) hold(6);
    repeat (6) begin
      hold(7);
      hold(8);
    end
    repeat (4) hold(LIMIT);
    repeat (LIMIT + 8) step(1'b0);
    step(1'b1);
    repeat (4) hold(1);
    repeat (3) hold(2);
    hold(LIMIT + 1);
    repeat (60) hold(int'($urandom_range(1, LIMIT + 4)));
    repeat (3) hold(9);
    repeat (4) step(1'b0);
    do_reset(1'b1);
    repeat (3) hold(10);
    repeat (40) hold(int'($urandom_range(1, LIMIT + 8)));
    repeat (LIMIT + 2 * LAT + 4) step(1'b0);
    check_eq("drain", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
